// File: rtl/pipe_sched.sv
// rtl/pipe_sched.sv - 5-stage pipeline sequencer: run/halt/step FSM, hazard stalls, regfile port-A arbitration
// Optional PIPE_SCHED_PERF_EN adds saturating cycle and stall counters.
module pipe_sched #(
    parameter int RA_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PAUSE,
    input  logic             STEP_PULSE,
    input  logic [RA_W-1:0]  ID_rs,
    input  logic             ID_rs_used,
    input  logic [RA_W-1:0]  ID_rt,
    input  logic             ID_rt_used,
    input  logic             IDEX_memread,
    input  logic [RA_W-1:0]  IDEX_wa,
    input  logic             WB_regwrite,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             rf_we,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_HALT;
        end else begin
            case (state)
                S_HALT: begin
                    if (!PAUSE)
                        state <= S_RUN;
                    else if (STEP_PULSE)
                        state <= S_STEP;
                    else
                        state <= S_HALT;
                end
                S_RUN:   state <= PAUSE ? S_HALT : S_RUN;
                S_STEP:  state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

    logic adv;
    logic load_use;
    logic port_a_conflict;
    logic stall;

    assign adv = (state == S_RUN) || (state == S_STEP);

    assign load_use = IDEX_memread &&
                      ((ID_rs_used && (ID_rs == IDEX_wa)) ||
                       (ID_rt_used && (ID_rt == IDEX_wa)));

    // WB owns port A whenever it writes; the ID rs read is retried after the bubble.
    assign port_a_conflict = WB_regwrite && ID_rs_used;

    assign stall = adv && (load_use || port_a_conflict);

    assign idex_we     = adv;
    assign exmem_we    = adv;
    assign memwb_we    = adv;
    assign pc_we       = adv && !stall;
    assign ifid_we     = adv && !stall;
    assign idex_bubble = stall;
    assign rf_we       = adv && WB_regwrite;
    assign halted      = (state == S_HALT);

`ifdef PIPE_SCHED_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (adv && (cyc_q != CNT_MAX))
                cyc_q <= cyc_q + CNT_ONE;
            if (stall && (stall_q != CNT_MAX))
                stall_q <= stall_q + CNT_ONE;
        end
    end

    assign cyc_cnt   = cyc_q;
    assign stall_cnt = stall_q;
`else
    assign cyc_cnt   = '0;
    assign stall_cnt = '0;
`endif

endmodule
